// File: rtl/vp_sequencer.sv
// Vector instruction sequencer: fetches ROM words and expands each vector
// instruction into per-element op_code issues with a valid/ready handshake.
module vp_sequencer #(
  parameter int PC_W   = 8,
  parameter int LEN_W  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_rd,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [2:0]        op_code,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [LEN_W-1:0]  elem_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for start; done pulses here after HALT
  // FETCH  | ROM read strobe at pc
  // LOAD   | latch/decode ROM word; LOOP and HALT resolved here
  // ISSUE  | one element per accepted handshake
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_ISSUE} state_t;

  localparam logic [2:0] OP_LOOP = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b011;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [15:0]        ir_q, ir_d;
  logic [LEN_W-1:0]   elem_q, elem_d;
  logic [LEN_W-1:0]   loop_cnt_q, loop_cnt_d;
  logic               loop_armed_q, loop_armed_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   ld_cnt;
  logic [PC_W-1:0]    ld_tgt;

  assign ld_cnt = LEN_W'(imem_data[12:8]);
  assign ld_tgt = PC_W'(imem_data[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      elem_q       <= '0;
      loop_cnt_q   <= '0;
      loop_armed_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      elem_q       <= elem_d;
      loop_cnt_q   <= loop_cnt_d;
      loop_armed_q <= loop_armed_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    elem_d       = elem_q;
    loop_cnt_d   = loop_cnt_q;
    loop_armed_d = loop_armed_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d   = imem_data;
        elem_d = '0;
        case (imem_data[15:13])
          OP_HALT: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
          OP_LOOP: begin
            state_d = S_FETCH;
            if (!loop_armed_q) begin
              loop_cnt_d   = ld_cnt;
              loop_armed_d = 1'b1;
              pc_d         = (ld_cnt != '0) ? ld_tgt : pc_q + 1'b1;
            end else if (loop_cnt_q != LEN_W'(1)) begin
              loop_cnt_d = loop_cnt_q - 1'b1;
              pc_d       = ld_tgt;
            end else begin
              loop_armed_d = 1'b0;
              pc_d         = pc_q + 1'b1;
            end
          end
          default: state_d = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (op_ready) begin
          if (elem_q == LEN_W'(ir_q[12:8])) begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // op_code/mem_addr are forced to zero outside ISSUE so they read clean when idle
  always_comb begin
    op_valid  = (state_q == S_ISSUE);
    imem_rd   = (state_q == S_FETCH);
    busy      = (state_q != S_IDLE);
    imem_addr = pc_q;
    pc        = pc_q;
    elem_idx  = elem_q;
    done      = done_q;
    op_code   = '0;
    mem_addr  = '0;
    if (state_q == S_ISSUE) begin
      op_code  = ir_q[15:13];
      mem_addr = ADDR_W'(ir_q[7:0]) + ADDR_W'(elem_q);
    end
  end

endmodule

// File: tb/tb_vp_sequencer.sv
// Directed bench for vp_sequencer: small ROM programs with hand-computed
// issue streams, timing, wrap, loop, reset and start-while-busy cases.
module tb_vp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic [2:0]  op_code;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [4:0]  elem_idx;
  logic [7:0]  mem_addr;
  logic [7:0]  pc;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] rom [256];

  int q_code[$];
  int q_idx[$];
  int q_addr[$];
  int q_cyc[$];
  int done_count = 0;
  int done_cyc = 0;
  int done_busy = 0;
  int overlap = 0;
  int hold_err = 0;
  int stalls = 0;
  bit prev_stall = 1'b0;
  logic [4:0] prev_idx = '0;
  logic [7:0] prev_addr = '0;
  logic [2:0] prev_code = '0;

  vp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_rd(imem_rd),
    .imem_addr(imem_addr), .imem_data(imem_data), .op_code(op_code),
    .op_valid(op_valid), .op_ready(op_ready), .elem_idx(elem_idx),
    .mem_addr(mem_addr), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_rd) imem_data <= rom[imem_addr];
  end

  always @(negedge clk) begin
    if (op_valid && op_ready) begin
      q_code.push_back(int'(op_code));
      q_idx.push_back(int'(elem_idx));
      q_addr.push_back(int'(mem_addr));
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_count = done_count + 1;
      done_cyc   = cyc;
      done_busy  = int'(busy);
    end
    if ((done && op_valid) || (imem_rd && op_valid)) overlap = overlap + 1;
    if (prev_stall && op_valid &&
        (elem_idx != prev_idx || mem_addr != prev_addr || op_code != prev_code))
      hold_err = hold_err + 1;
    if (op_valid && !op_ready) stalls = stalls + 1;
    prev_stall = op_valid && !op_ready;
    prev_idx   = elem_idx;
    prev_addr  = mem_addr;
    prev_code  = op_code;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2);
    for (int i = 0; i < 256; i++) rom[i] = 16'h6000;
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
  endtask

  // mode 0: op_ready high, mode 1: op_ready toggles every cycle
  task automatic run_prog(input int mode, input bit extra_start,
                          output int s, output int base);
    int dc0;
    bit finished;
    base = q_code.size();
    dc0  = done_count;
    finished = 1'b0;
    op_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done_count != dc0) begin
        finished = 1'b1;
        break;
      end
      if (mode == 1) op_ready = ~op_ready;
      start = (extra_start && i == 4);
    end
    start = 1'b0;
    if (!finished) chk("run_timeout", 0, 1);
  endtask

  int s, b;
  bit seen;

  initial begin
    load_rom(16'h0310, 16'h6000, 16'h6000);
    #23;
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_done_rd", int'({done, imem_rd}), 0);
    chk("rst_code_addr_idx", int'({op_code, mem_addr, elem_idx}), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // basic vector of 4, ready high
    run_prog(0, 1'b0, s, b);
    chk("t1_count", q_code.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_code%0d", i), q_code[b+i], 0);
      chk($sformatf("t1_idx%0d", i), q_idx[b+i], i);
      chk($sformatf("t1_addr%0d", i), q_addr[b+i], 'h10 + i);
      chk($sformatf("t1_cyc%0d", i), q_cyc[b+i] - s, 3 + i);
    end
    chk("t1_done_cyc", done_cyc - s, 9);
    chk("t1_done_busy", done_busy, 0);
    chk("t1_pc_after_halt", int'(pc), 1);

    // toggling ready
    stalls = 0;
    run_prog(1, 1'b0, s, b);
    chk("t2_count", q_code.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_idx%0d", i), q_idx[b+i], i);
      chk($sformatf("t2_addr%0d", i), q_addr[b+i], 'h10 + i);
    end
    chk("t2_stalls_seen", int'(stalls > 0), 1);

    // mem_addr wrap
    load_rom(16'hA1FF, 16'h6000, 16'h6000);
    run_prog(0, 1'b0, s, b);
    chk("t3_count", q_code.size() - b, 2);
    chk("t3_addr0", q_addr[b], 'hFF);
    chk("t3_addr1", q_addr[b+1], 'h00);
    chk("t3_code", q_code[b+1], 5);

    // loop body runs C+1 = 3 times; rerun proves the loop disarmed
    load_rom(16'h8020, 16'h4200, 16'h6000);
    for (int r = 0; r < 2; r++) begin
      run_prog(0, 1'b0, s, b);
      chk($sformatf("t4_count_run%0d", r), q_code.size() - b, 3);
      for (int i = 0; i < q_code.size() - b; i++)
        chk($sformatf("t4_addr_code%0d", i), q_addr[b+i] * 8 + q_code[b+i], 'h20 * 8 + 4);
      chk($sformatf("t4_pc_run%0d", r), int'(pc), 2);
    end

    // maximum length field: 32 elements
    load_rom(16'h3F00, 16'h6000, 16'h6000);
    run_prog(0, 1'b0, s, b);
    chk("t7_count", q_code.size() - b, 32);
    chk("t7_last_idx", q_idx[q_idx.size()-1], 31);
    chk("t7_last_addr", q_addr[q_addr.size()-1], 31);
    chk("t7_done_cyc", done_cyc - s, 37);

    // async reset mid-issue with op_ready low
    load_rom(16'h0310, 16'h6000, 16'h6000);
    op_ready = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (op_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t5_valid_seen", int'(seen), 1);
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(op_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_pc", int'(pc), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    run_prog(0, 1'b0, s, b);
    chk("t5_restart_count", q_code.size() - b, 4);
    chk("t5_restart_addr0", q_addr[b], 'h10);
    chk("t5_restart_cyc0", q_cyc[b] - s, 3);

    // start pulsed while busy has no effect
    run_prog(0, 1'b1, s, b);
    chk("t6_count", q_code.size() - b, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t6_cyc%0d", i), (q_cyc[b+i] - s) * 256 + q_addr[b+i], (3 + i) * 256 + 'h10 + i);
    chk("t6_done_cyc", done_cyc - s, 9);

    chk("never_done_or_rd_with_valid", overlap, 0);
    chk("hold_while_stalled", hold_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
